serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, BITS_PER_CYCLE bits per clock.
//   Operands are captured on a start handshake. Sum, carry-out and signed overflow are returned with a one-cycle done pulse.
//   Successor to the 1-bit combinational half adder; building block for the datapath/ALU of the exercise set.
// PARAMETERS
//   WIDTH           8   operand/sum width in bits (>=2)
//   BITS_PER_CYCLE  1   bits processed per clock; must divide WIDTH (elaboration error otherwise)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      synchronous reset, active-low
//   start  in   1      request; sampled only when idle or done
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   sub    in   1      subtract request (only with SERIAL_ADDER_SUB_EN, see CONFIGURATION)
//   busy   out  1      high while state==RUN
//   done   out  1      one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum    out  WIDTH  result, held until next accepted start
//   cout   out  1      carry out of MSB
//   ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - K = WIDTH/BITS_PER_CYCLE. FSM states IDLE, RUN, DONE.
//   - Reset (rst_n==0 at a clock edge): state=IDLE; busy, done, sum, cout, ovf, internal count/carry/shift regs all 0.
//     Reset mid-RUN aborts the operation; no done pulse is produced.
//   - IDLE: start==1 -> capture a, b, cin into shift regs/carry reg, count=0, go RUN. Else stay.
//   - RUN: each edge adds the low BITS_PER_CYCLE bits of A/B regs plus the carry reg.
//     Result chunk shifts into sum reg from the MSB side; A/B shift right by BITS_PER_CYCLE; carry reg updated; count++.
//     The edge that processes chunk K-1 goes to DONE.
//     cout and ovf are taken from that final chunk: ovf uses the carry into bit WIDTH-1.
//   - DONE: done=1 for exactly this cycle.
//     start==1 -> accepted exactly as in IDLE (back-to-back, go RUN). Else go IDLE.
//   - Latency: done is high K cycles after the edge that accepted start. Throughput: one op per K+1 cycles.
//   - start while RUN: ignored, no effect on operands or timing.
//   - sum/cout/ovf update only when RUN ends; they hold their values through IDLE and the next RUN until the next done.
//     During RUN the sum reg is partially shifted; it is valid only from done onwards.
//     Implementation: separate shift and output regs, so outputs are stable during RUN.
//   - Arithmetic is modulo 2^WIDTH; cout is the (WIDTH+1)th bit. No saturation.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined:
//     - sub is captured with the operands. sub==1 computes a - b as a + ~b + 1.
//     - Captured cin is ignored when sub==1; the carry reg is forced to 1.
//     - cout==1 means no borrow. ovf is signed overflow of the subtraction.
//   SERIAL_ADDER_SUB_EN not defined:
//     - sub port is present but ignored. Add-only datapath; no operand inversion logic.
// TESTING
//   (W=8, BPC=1 unless noted; start is a 1-cycle pulse)
//   - a=0x0F b=0x01 cin=0 -> done 8 cycles after start; sum=0x10, cout=0, ovf=0; busy high 8 cycles.
//   - a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0.
//     a=0x7F b=0x00 cin=1 -> sum=0x80, cout=0, ovf=1.
//   - a=0x12 b=0x34, then start again with a=0xFF after 3 cycles -> start ignored; sum=0x46 at done.
//     Start again in the done cycle -> second result 9 cycles after first done.
//   - Reset: rst_n low 1 cycle at RUN cycle 4 -> busy=done=sum=cout=ovf=0 next cycle; no done pulse ever for that op.
//   - BPC=4, W=8: a=0x99 b=0x99 cin=0 -> sum=0x32, cout=1, ovf=1, done 2 cycles after start.
//   - SERIAL_ADDER_SUB_EN, sub=1: a=0x05 b=0x07 -> sum=0xFE, cout=0, ovf=0.
//     a=0x80 b=0x01 -> sum=0x7F, cout=1, ovf=1.
//     Without the macro, same stimulus with sub=1 -> plain add: 0x0C, 0x81.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands plus carry-in, BITS_PER_CYCLE bits per clock.
// Optional subtract datapath enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int K  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [B:0] chunk_add(input logic [B-1:0] x, input logic [B-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{B{1'b0}}, c};
  endfunction

  state_t           state_r, state_n;
  logic             accept_s;
  logic [WIDTH-1:0] a_r, b_r, acc_r, sum_r;
  logic             carry_r, busy_r, done_r, cout_r, ovf_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] b_in_s;
  logic             c_in_s;
  logic [B:0]       chunk_s;
  logic             msb_cin_s, last_s;
  logic [WIDTH+B-1:0] ext_s;
  logic [WIDTH-1:0] acc_next_s;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1: invert B at capture and force the carry in.
  assign b_in_s = sub ? ~b : b;
  assign c_in_s = sub ? 1'b1 : cin;
`else
  logic unused_sub_s;
  assign b_in_s       = b;
  assign c_in_s       = cin;
  assign unused_sub_s = sub;
`endif

  assign chunk_s    = chunk_add(a_r[B-1:0], b_r[B-1:0], carry_r);
  // Carry into the chunk's top bit recovered from its sum bit; on the last chunk this is bit WIDTH-1.
  assign msb_cin_s  = chunk_s[B-1] ^ a_r[B-1] ^ b_r[B-1];
  assign ext_s      = {chunk_s[B-1:0], acc_r};
  assign acc_next_s = ext_s[WIDTH+B-1:B];
  assign last_s     = (cnt_r == CW'(K - 1));

  // Next-state decode and start acceptance.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_n  = RUN;
        end else begin
          state_n  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_n  = RUN;
        end else begin
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == RUN);
      done_r  <= (state_n == DONE);
    end
  end

  // Operand shift registers, running carry and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b_in_s;
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= c_in_s;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_r     <= a_r >> B;
      b_r     <= b_r >> B;
      acc_r   <= acc_next_s;
      carry_r <= chunk_s[B];
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        sum_r  <= acc_next_s;
        cout_r <= chunk_s[B];
        ovf_r  <= msb_cin_s ^ chunk_s[B];
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
